text_console: RTL and testbench

TEXT_CONSOLE -- requirements
Module: text_console

---
 rtl/video_pkg.sv | 23 ++
 rtl/text_console.sv | 166 ++++++++++++++++
 tb/tb_text_console.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_pkg.sv
// Shared video geometry: buffer placement and size, the blank fill code,
// the console control codes, and the cell address helper.
package video_pkg;

    localparam int unsigned COLS      = 64;
    localparam int unsigned ROWS      = 40;
    localparam logic [15:0] BASE_ADDR = 16'hF600;
    localparam logic [7:0]  BLANK     = 8'h20;

    localparam logic [7:0] CHAR_BS = 8'h08;
    localparam logic [7:0] CHAR_LF = 8'h0A;
    localparam logic [7:0] CHAR_FF = 8'h0C;
    localparam logic [7:0] CHAR_CR = 8'h0D;

    // Address of the cell at (col, row); wraps modulo 2^16.
    function automatic logic [15:0] cell_addr(input logic [15:0] base,
                                              input int unsigned cols,
                                              input logic [5:0]  col,
                                              input logic [5:0]  row);
        return base + 16'(row) * 16'(cols) + 16'(col);
    endfunction

endpackage

// File: rtl/text_console.sv
// Character terminal writer: accepts a byte stream, places glyphs into the
// character buffer, interprets CR/BS/LF/FF and scrolls or clears the buffer.
module text_console #(
    parameter int unsigned COLS      = video_pkg::COLS,
    parameter int unsigned ROWS      = video_pkg::ROWS,
    parameter logic [15:0] BASE_ADDR = video_pkg::BASE_ADDR,
    parameter logic [7:0]  BLANK     = video_pkg::BLANK
) (
    input  logic        clk_pixel,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [15:0] mem_addr,
    output logic        mem_en,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic [5:0]  cursor_col,
    output logic [5:0]  cursor_row,
    output logic        busy
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WRITE     = 3'd1;
    localparam logic [2:0] S_SCROLL_RD = 3'd2;
    localparam logic [2:0] S_SCROLL_WR = 3'd3;
    localparam logic [2:0] S_CLEAR_ALL = 3'd4;
    localparam logic [2:0] S_CLEAR_ROW = 3'd5;

    localparam logic [15:0] CELLS         = 16'(COLS * ROWS);
    localparam logic [15:0] LAST_ADDR     = BASE_ADDR + CELLS - 16'd1;
    localparam logic [15:0] SRC_FIRST     = BASE_ADDR + 16'(COLS);
    localparam logic [15:0] LAST_ROW_ADDR = BASE_ADDR + 16'((ROWS - 1) * COLS);
    localparam logic [5:0]  COL_MAX       = 6'(COLS - 1);
    localparam logic [5:0]  ROW_MAX       = 6'(ROWS - 1);

    logic [2:0]  state_q, state_d;
    logic [5:0]  col_q, col_d;
    logic [5:0]  row_q, row_d;
    logic [15:0] ptr_q, ptr_d;    // write target, scroll source or clear pointer
    logic [7:0]  char_q, char_d;  // glyph waiting in WRITE
    // Low while reset is held and for nothing else: it keeps the strobes
    // quiet in the reset state even though that state is CLEAR_ALL.
    logic        live_q;

    // Next-state logic: byte decode in IDLE, cursor advance, scroll and clear stepping.
    always_comb begin
        // NOTE: every signal gets a default first so no latch is inferred.
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        ptr_d   = ptr_q;
        char_d  = char_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    case (in_data)
                        video_pkg::CHAR_CR: col_d = 6'd0;
                        video_pkg::CHAR_BS: begin
                            if (col_q != 6'd0) col_d = col_q - 6'd1;
                        end
                        video_pkg::CHAR_LF: begin
                            if (row_q != ROW_MAX) begin
                                row_d = row_q + 6'd1;
                            end else begin
                                state_d = S_SCROLL_RD;
                                ptr_d   = SRC_FIRST;
                            end
                        end
                        video_pkg::CHAR_FF: begin
                            col_d   = 6'd0;
                            row_d   = 6'd0;
                            state_d = S_CLEAR_ALL;
                            ptr_d   = BASE_ADDR;
                        end
                        default: begin
                            state_d = S_WRITE;
                            ptr_d   = video_pkg::cell_addr(BASE_ADDR, COLS, col_q, row_q);
                            char_d  = in_data;
                        end
                    endcase
                end
            end
            S_WRITE: begin
                if (col_q != COL_MAX) begin
                    col_d   = col_q + 6'd1;
                    state_d = S_IDLE;
                end else if (row_q != ROW_MAX) begin
                    col_d   = 6'd0;
                    row_d   = row_q + 6'd1;
                    state_d = S_IDLE;
                end else begin
                    col_d   = 6'd0;
                    state_d = S_SCROLL_RD;
                    ptr_d   = SRC_FIRST;
                end
            end
            S_SCROLL_RD: state_d = S_SCROLL_WR;
            S_SCROLL_WR: begin
                if (ptr_q == LAST_ADDR) begin
                    state_d = S_CLEAR_ROW;
                    ptr_d   = LAST_ROW_ADDR;
                end else begin
                    state_d = S_SCROLL_RD;
                    ptr_d   = ptr_q + 16'd1;
                end
            end
            S_CLEAR_ALL: begin
                if (live_q) begin
                    if (ptr_q == LAST_ADDR) state_d = S_IDLE;
                    else                    ptr_d   = ptr_q + 16'd1;
                end
            end
            S_CLEAR_ROW: begin
                if (ptr_q == LAST_ADDR) begin
                    state_d = S_IDLE;
                    col_d   = 6'd0;
                    row_d   = ROW_MAX;
                end else begin
                    ptr_d = ptr_q + 16'd1;
                end
            end
            default: begin
                state_d = S_CLEAR_ALL;
                ptr_d   = BASE_ADDR;
            end
        endcase
    end

    // State registers with synchronous reset into a held, silent clear.
    always_ff @(posedge clk_pixel) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (reset) begin
            state_q <= S_CLEAR_ALL;
            col_q   <= 6'd0;
            row_q   <= 6'd0;
            ptr_q   <= BASE_ADDR;
            char_q  <= BLANK;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            ptr_q   <= ptr_d;
            char_q  <= char_d;
            live_q  <= 1'b1;
        end
    end

    // Output decode from registered state only; scroll write data is the RAM read return.
    always_comb begin
        in_ready   = (state_q == S_IDLE);
        busy       = (state_q == S_SCROLL_RD) || (state_q == S_SCROLL_WR) ||
                     (state_q == S_CLEAR_ALL) || (state_q == S_CLEAR_ROW);
        mem_en     = live_q && (state_q != S_IDLE);
        mem_we     = mem_en && (state_q != S_SCROLL_RD);
        mem_addr   = (state_q == S_SCROLL_WR) ? (ptr_q - 16'(COLS)) : ptr_q;
        mem_wdata  = BLANK;
        if (state_q == S_WRITE)     mem_wdata = char_q;
        if (state_q == S_SCROLL_WR) mem_wdata = mem_rdata;
        cursor_col = col_q;
        cursor_row = row_q;
    end

endmodule

// File: tb/tb_text_console.sv
// Directed bench for text_console with a synchronous-read RAM model and an
// expected-buffer image maintained by the tests.
module tb_text_console;

    logic        clk_pixel = 1'b0;
    logic        reset     = 1'b1;
    logic        in_valid  = 1'b0;
    logic [7:0]  in_data   = 8'h00;
    logic        in_ready;
    logic [15:0] mem_addr;
    logic        mem_en;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic [5:0]  cursor_col;
    logic [5:0]  cursor_row;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int en_pulses = 0;

    logic [7:0] ram  [0:65535];
    logic [7:0] expv [0:2559];

    always #5 clk_pixel = ~clk_pixel;

    text_console dut (
        .clk_pixel (clk_pixel),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_addr  (mem_addr),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .cursor_col(cursor_col),
        .cursor_row(cursor_row),
        .busy      (busy)
    );

    // Synchronous RAM: write on the edge, read data valid the next cycle.
    always @(posedge clk_pixel) begin
        if (mem_en === 1'b1) begin
            if (mem_we === 1'b1) ram[mem_addr] <= mem_wdata;
            else                 mem_rdata <= ram[mem_addr];
        end
    end

    always @(negedge clk_pixel) begin
        if (mem_en === 1'b1) en_pulses++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time exceeded, required completion");
        $fatal(1, "watchdog expired");
    end

    // Offer one byte; returns at the negedge of the cycle after acceptance.
    task automatic send(input logic [7:0] b);
        int waited = 0;
        while (in_ready !== 1'b1 && waited < 20000) begin
            @(negedge clk_pixel);
            waited++;
        end
        if (in_ready !== 1'b1) begin
            total++; bad++;
            $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
        end
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk_pixel);
        in_valid = 1'b0;
    endtask

    task automatic put(input int col, input int row, input logic [7:0] ch);
        send(ch);
        expv[row * 64 + col] = ch;
    endtask

    // Walks a full clear starting in its first write cycle; counts deviations.
    task automatic run_clear(output int errs);
        errs = 0;
        for (int i = 0; i < 2560; i++) begin
            if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'(16'hF600 + i) ||
                mem_wdata !== 8'h20 || busy !== 1'b1 || in_ready !== 1'b0) errs++;
            @(negedge clk_pixel);
        end
    endtask

    task automatic ram_errs(output int errs);
        errs = 0;
        for (int k = 0; k < 2560; k++)
            if (ram[16'hF600 + k] !== expv[k]) errs++;
    endtask

    task automatic check_cursor(input string name, input int col, input int row);
        total++;
        if (cursor_col !== 6'(col) || cursor_row !== 6'(row)) begin
            bad++;
            $display("FAIL %s: cursor=(%0d,%0d) required (%0d,%0d)", name, cursor_col, cursor_row, col, row);
        end
    endtask

    task automatic test_reset();
        int errs;
        reset = 1'b1; in_valid = 1'b1; in_data = 8'h51;
        repeat (3) @(negedge clk_pixel);
        total++;
        if (mem_en !== 1'b0 || mem_we !== 1'b0) begin
            bad++; $display("FAIL reset_strobes: en=%b we=%b required 0 0", mem_en, mem_we);
        end
        total++;
        if (mem_addr !== 16'hF600 || mem_wdata !== 8'h20) begin
            bad++; $display("FAIL reset_addr_data: addr=%h wdata=%h required f600 20", mem_addr, mem_wdata);
        end
        total++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL reset_flags: ready=%b busy=%b required 0 1", in_ready, busy);
        end
        check_cursor("reset_cursor", 0, 0);
        reset = 1'b0;
        @(negedge clk_pixel);
        run_clear(errs);
        in_valid = 1'b0;
        total++;
        if (errs != 0) begin
            bad++; $display("FAIL reset_clear_sequence: bad_cycles=%0d required 0", errs);
        end
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || mem_en !== 1'b0) begin
            bad++; $display("FAIL reset_ready_after_clear: ready=%b busy=%b en=%b required 1 0 0", in_ready, busy, mem_en);
        end
        check_cursor("reset_cursor_after_clear", 0, 0);
        for (int k = 0; k < 2560; k++) expv[k] = 8'h20;
    endtask

    task automatic test_glyph();
        put(0, 0, 8'h41);
        total++;
        if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'hF600 || mem_wdata !== 8'h41) begin
            bad++; $display("FAIL glyph_write: en=%b we=%b addr=%h data=%h required 1 1 f600 41", mem_en, mem_we, mem_addr, mem_wdata);
        end
        total++;
        if (in_ready !== 1'b0) begin
            bad++; $display("FAIL glyph_ready_low: ready=%b required 0", in_ready);
        end
        @(negedge clk_pixel);
        total++;
        if (in_ready !== 1'b1 || mem_en !== 1'b0) begin
            bad++; $display("FAIL glyph_ready_return: ready=%b en=%b required 1 0", in_ready, mem_en);
        end
        check_cursor("glyph_cursor", 1, 0);
    endtask

    task automatic test_controls();
        int p0;
        p0 = en_pulses;
        send(8'h0D);
        check_cursor("cr_cursor", 0, 0);
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL cr_stays_idle: ready=%b required 1", in_ready);
        end
        repeat (3) send(8'h0A);
        check_cursor("lf_cursor", 0, 3);
        total++;
        if (en_pulses != p0) begin
            bad++; $display("FAIL control_no_access_a: pulses=%0d required %0d", en_pulses, p0);
        end
        put(0, 3, 8'h42);
        put(1, 3, 8'h43);
        @(negedge clk_pixel);
        p0 = en_pulses;
        send(8'h0D);
        check_cursor("cr_row3", 0, 3);
        send(8'h08);
        check_cursor("bs_at_col0", 0, 3);
        send(8'h0A);
        check_cursor("lf_row4", 0, 4);
        total++;
        if (en_pulses != p0) begin
            bad++; $display("FAIL control_no_access_b: pulses=%0d required %0d", en_pulses, p0);
        end
        put(0, 4, 8'h58);
        send(8'h08);
        check_cursor("bs_decrement", 0, 4);
        total++;
        if (ram[16'hF700] !== 8'h58) begin
            bad++; $display("FAIL bs_no_erase: ram[f700]=%h required 58", ram[16'hF700]);
        end
        send(8'h0A);
        check_cursor("lf_row5", 0, 5);
    endtask

    task automatic test_row_wrap();
        int errs;
        for (int i = 0; i < 63; i++) put(i, 5, 8'(8'h40 + i));
        put(63, 5, 8'h7F);
        total++;
        if (mem_we !== 1'b1 || mem_addr !== 16'hF77F || mem_wdata !== 8'h7F) begin
            bad++; $display("FAIL row_last_write: we=%b addr=%h data=%h required 1 f77f 7f", mem_we, mem_addr, mem_wdata);
        end
        @(negedge clk_pixel);
        check_cursor("row_wrap_cursor", 0, 6);
        ram_errs(errs);
        total++;
        if (errs != 0) begin
            bad++; $display("FAIL row_wrap_buffer: bad_cells=%0d required 0", errs);
        end
    endtask

    task automatic test_scroll();
        int rd_errs = 0;
        int wr_errs = 0;
        int cl_errs = 0;
        int errs;
        repeat (33) send(8'h0A);
        check_cursor("scroll_setup_row", 0, 39);
        for (int i = 0; i < 63; i++) put(i, 39, 8'(8'h61 + (i % 26)));
        put(63, 39, 8'h5A);
        total++;
        if (mem_we !== 1'b1 || mem_addr !== 16'hFFFF || mem_wdata !== 8'h5A) begin
            bad++; $display("FAIL scroll_last_glyph: we=%b addr=%h data=%h required 1 ffff 5a", mem_we, mem_addr, mem_wdata);
        end
        check_cursor("scroll_write_cursor", 63, 39);
        @(negedge clk_pixel);
        for (int i = 0; i < 2496; i++) begin
            if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'(16'hF640 + i) || busy !== 1'b1) rd_errs++;
            @(negedge clk_pixel);
            if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'(16'hF600 + i) ||
                mem_wdata !== expv[64 + i] || busy !== 1'b1) wr_errs++;
            @(negedge clk_pixel);
        end
        for (int i = 0; i < 64; i++) begin
            if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'(16'hFFC0 + i) ||
                mem_wdata !== 8'h20 || busy !== 1'b1) cl_errs++;
            @(negedge clk_pixel);
        end
        total++;
        if (rd_errs != 0) begin
            bad++; $display("FAIL scroll_reads: bad_cycles=%0d required 0", rd_errs);
        end
        total++;
        if (wr_errs != 0) begin
            bad++; $display("FAIL scroll_writes: bad_cycles=%0d required 0", wr_errs);
        end
        total++;
        if (cl_errs != 0) begin
            bad++; $display("FAIL scroll_clear_row: bad_cycles=%0d required 0", cl_errs);
        end
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL scroll_done: ready=%b busy=%b required 1 0", in_ready, busy);
        end
        check_cursor("scroll_cursor", 0, 39);
        for (int k = 0; k < 2496; k++) expv[k] = expv[k + 64];
        for (int k = 2496; k < 2560; k++) expv[k] = 8'h20;
        ram_errs(errs);
        total++;
        if (errs != 0) begin
            bad++; $display("FAIL scroll_buffer: bad_cells=%0d required 0", errs);
        end
    endtask

    task automatic test_reset_mid_scroll();
        int quiet_errs = 0;
        int errs;
        send(8'h0A);
        in_valid = 1'b1; in_data = 8'h51;
        repeat (200) @(negedge clk_pixel);
        total++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            bad++; $display("FAIL midscroll_busy: busy=%b ready=%b required 1 0", busy, in_ready);
        end
        check_cursor("midscroll_ignore_input", 0, 39);
        reset = 1'b1;
        @(negedge clk_pixel);
        for (int i = 0; i < 4; i++) begin
            if (mem_en !== 1'b0 || mem_we !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) quiet_errs++;
            @(negedge clk_pixel);
        end
        total++;
        if (quiet_errs != 0) begin
            bad++; $display("FAIL midscroll_reset_quiet: bad_cycles=%0d required 0", quiet_errs);
        end
        check_cursor("midscroll_reset_cursor", 0, 0);
        reset = 1'b0;
        @(negedge clk_pixel);
        run_clear(errs);
        in_valid = 1'b0;
        total++;
        if (errs != 0) begin
            bad++; $display("FAIL midscroll_full_clear: bad_cycles=%0d required 0", errs);
        end
        total++;
        if (in_ready !== 1'b1 || ram[16'hF600] !== 8'h20) begin
            bad++; $display("FAIL midscroll_after: ready=%b ram[f600]=%h required 1 20", in_ready, ram[16'hF600]);
        end
        check_cursor("midscroll_after_cursor", 0, 0);
    endtask

    task automatic test_form_feed();
        int errs;
        put(0, 0, 8'h4D);
        put(1, 0, 8'h4E);
        send(8'h0C);
        check_cursor("ff_cursor", 0, 0);
        run_clear(errs);
        total++;
        if (errs != 0) begin
            bad++; $display("FAIL ff_clear_sequence: bad_cycles=%0d required 0", errs);
        end
        total++;
        if (in_ready !== 1'b1 || ram[16'hF601] !== 8'h20) begin
            bad++; $display("FAIL ff_done: ready=%b ram[f601]=%h required 1 20", in_ready, ram[16'hF601]);
        end
    endtask

    initial begin
        test_reset();
        test_glyph();
        test_controls();
        test_row_wrap();
        test_scroll();
        test_reset_mid_scroll();
        test_form_feed();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
